row_write_back: RTL and testbench
=================================

ROW_WRITE_BACK -- requirements
Module: row_write_back

Interface
REQ-001 SHALL have parameter ROW_W, default 5120, row width in bits (640 pixels x 8 bit).
REQ-002 SHALL have parameter ADDR_W, default 9, SRAM row-address width.
REQ-003 SHALL have parameter NUM_ROWS, default 480, rows per frame.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port sys_mode  input  3  system state (SYS_IDLE=0, SYS_GAUSSIAN=1, SYS_DETECT_FILTER=2).
REQ-007 SHALL have port start  input  1  one-cycle frame start pulse.
REQ-008 SHALL have port blur_sel  input  2  target blur SRAM index 0..3, sampled on accepted start.
REQ-009 SHALL have port in_valid  input  1  producer row valid.
REQ-010 SHALL have port in_ready  output  1  block can accept a row.
REQ-011 SHALL have port in_data  input  ROW_W  blurred row from the Gaussian engine.
REQ-012 SHALL have port sram_we  output  4  one-hot write strobe per blur SRAM.
REQ-013 SHALL have port sram_addr  output  ADDR_W  row address.
REQ-014 SHALL have port sram_wdata  output  ROW_W  row write data.
REQ-015 SHALL have port busy  output  1  high when the FSM is not in IDLE.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse when the frame is complete.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-018 SHALL move IDLE->RUN on start && sys_mode==SYS_GAUSSIAN, latching blur_sel and clearing acc_cnt/wr_cnt; SHALL ignore start in any other state or mode.
REQ-019 SHALL drive in_ready = (state==RUN) && FIFO not full; a row transfers on in_valid && in_ready.
REQ-020 SHALL buffer rows in a 2-entry FIFO; push and pop in the same cycle SHALL be legal, giving a sustained rate of 1 row/cycle.
REQ-021 SHALL pop the FIFO head every cycle the FIFO is non-empty in RUN or DRAIN.
REQ-022 SHALL register outputs on each pop: sram_we = 1<<sel_latched, sram_addr = wr_cnt, sram_wdata = head, wr_cnt += 1; SHALL hold sram_we at 0 in every other cycle.
REQ-023 SHALL give a latency into an empty FIFO of: handshake at edge k -> pop at edge k+1 -> sram_we high during the cycle after edge k+1.
REQ-024 SHALL move RUN->DRAIN when acc_cnt reaches NUM_ROWS; in_ready SHALL then stay low.
REQ-025 SHALL move DRAIN->DONE when wr_cnt reaches NUM_ROWS; DONE SHALL assert frame_done for one cycle and return to IDLE on the next edge.
REQ-026 SHALL, when sys_mode==SYS_IDLE in any state, go to IDLE next edge: FIFO flushed, counters cleared, sram_we=0, no frame_done.
REQ-027 SHALL write sram_addr = exact row index 0..NUM_ROWS-1 with no wrap-around; writes beyond NUM_ROWS SHALL be impossible by construction.

Reset
REQ-028 SHALL, with rst_n low at a rising edge, set state=IDLE, FIFO empty, counters 0, in_ready=0, sram_we=0, sram_addr=0, sram_wdata=0, busy=0 and frame_done=0.
REQ-029 SHALL abandon any frame in progress on reset mid-frame, with no further SRAM writes.

Configuration
REQ-030 SHALL, with macro ROW_WB_BORDER_ZERO_EN defined, write sram_wdata=0 for row indices 0, 1, NUM_ROWS-2 and NUM_ROWS-1 (5x5 Gaussian border); handshake and timing SHALL be unchanged.
REQ-031 SHALL, without ROW_WB_BORDER_ZERO_EN, write every row as received.

Structure
REQ-032 SHALL take the SYS_* mode constants, the FSM state enum and the ROW_W default from the shared package sift_pkg.
REQ-033 SHALL implement the 2-entry FIFO as sub-module row_fifo2 (push, pop, full, empty, head), instantiated once.

Verification
REQ-034 SHALL cover: blur_sel=2, start, 480 back-to-back valid rows -> 480 writes, sram_we=4'b0100, addr 0..479 in order, one frame_done pulse.
REQ-035 SHALL cover: row data=pattern 0xA5.., handshake at edge k into an empty FIFO -> sram_we high in cycle k+2, wdata=0xA5...
REQ-036 SHALL cover: in_valid held high for 3 rows with the writer stalled via sys_mode toggling -> in_ready drops when the FIFO holds 2 rows, no row lost.
REQ-037 SHALL cover: sys_mode=SYS_IDLE after 100 rows -> sram_we=0 next cycle, busy=0, no frame_done; the next start restarts at addr 0.
REQ-038 SHALL cover: start with sys_mode=SYS_DETECT_FILTER, and start while busy -> both ignored.
REQ-039 SHALL cover: with ROW_WB_BORDER_ZERO_EN, all-ones rows -> addr 0, 1, 478, 479 written as 0, all other addresses written as all-ones.

Source files
------------

// File: rtl/sift_pkg.sv
// ============================================================================
// sift_pkg
// Shared constants and types for the SIFT front-end blocks: system mode
// encodings, the row write-back FSM states and the default row width.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sift_pkg;

  // System mode encodings driven on sys_mode
  localparam logic [2:0] SYS_IDLE          = 3'd0;
  localparam logic [2:0] SYS_GAUSSIAN      = 3'd1;
  localparam logic [2:0] SYS_DETECT_FILTER = 3'd2;

  // One image row: 640 pixels x 8 bit
  localparam int unsigned SIFT_ROW_W = 5120;

  // Row write-back FSM states
  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_RUN   = 2'd1,
    WB_DRAIN = 2'd2,
    WB_DONE  = 2'd3
  } wb_state_e;

endpackage : sift_pkg

`default_nettype wire

// File: rtl/row_fifo2.sv
// ============================================================================
// row_fifo2
// Two-entry row FIFO. Push and pop may happen in the same cycle; a push
// while full or a pop while empty is ignored. flush_i empties the FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module row_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; flush wins over push/pop
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Row storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule : row_fifo2

`default_nettype wire

// File: rtl/row_write_back.sv
// ============================================================================
// row_write_back
// Accepts blurred rows from the Gaussian engine through a 2-entry FIFO and
// writes them, in order, to one of four blur SRAMs at row address 0..N-1.
// The writer only advances while sys_mode is SYS_GAUSSIAN; any other
// non-idle mode stalls it, and SYS_IDLE abandons the frame.
// Optional build macro: ROW_WB_BORDER_ZERO_EN -- rows 0, 1, N-2 and N-1 are
// written as zero (5x5 Gaussian border), timing unchanged.
// Revision: 1.0
// ============================================================================
`default_nettype none

module row_write_back
  import sift_pkg::*;
#(
  parameter int unsigned ROW_W    = SIFT_ROW_W,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned NUM_ROWS = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        sys_mode,
  input  logic              start,
  input  logic [1:0]        blur_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROW_W-1:0]  in_data,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [ROW_W-1:0]  sram_wdata,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CNT_W = $clog2(NUM_ROWS + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_ROWS - 1);

  wb_state_e         state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROW_W-1:0]  wdata_q, wdata_d;

  logic              abort;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ROW_W-1:0]  fifo_head;
  logic [ROW_W-1:0]  row_out;

  assign abort     = (sys_mode == SYS_IDLE);
  assign in_ready  = (state_q == WB_RUN) && !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = ((state_q == WB_RUN) || (state_q == WB_DRAIN)) &&
                     !fifo_empty && (sys_mode == SYS_GAUSSIAN);

  row_fifo2 #(
    .W (ROW_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (abort),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (in_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

`ifdef ROW_WB_BORDER_ZERO_EN
  logic border_row;
  assign border_row = (wr_cnt_q == '0) || (wr_cnt_q == CNT_W'(1)) ||
                      (wr_cnt_q == CNT_W'(NUM_ROWS - 2)) || (wr_cnt_q == C_LAST);
  assign row_out    = border_row ? '0 : fifo_head;
`else
  assign row_out    = fifo_head;
`endif

  // Next-state, counter and write-port decode; abort overrides everything
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    acc_cnt_d = acc_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    we_d      = 4'b0000;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (abort) begin
      state_d   = WB_IDLE;
      acc_cnt_d = '0;
      wr_cnt_d  = '0;
    end else begin
      if (fifo_pop) begin
        we_d     = 4'b0001 << sel_q;
        addr_d   = ADDR_W'(wr_cnt_q);
        wdata_d  = row_out;
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
      case (state_q)
        WB_IDLE: begin
          if (start && (sys_mode == SYS_GAUSSIAN)) begin
            state_d   = WB_RUN;
            sel_d     = blur_sel;
            acc_cnt_d = '0;
            wr_cnt_d  = '0;
          end
        end
        WB_RUN: begin
          // Leave RUN on the edge that accepts the last row so in_ready
          // can never admit row NUM_ROWS
          if (fifo_push) begin
            acc_cnt_d = acc_cnt_q + 1'b1;
            if (acc_cnt_q == C_LAST) state_d = WB_DRAIN;
          end
        end
        WB_DRAIN: begin
          if (fifo_pop && (wr_cnt_q == C_LAST)) state_d = WB_DONE;
        end
        WB_DONE: state_d = WB_IDLE;
        default: state_d = WB_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WB_IDLE;
    else        state_q <= state_d;
  end

  // Counters, latched SRAM select and registered SRAM write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q     <= 2'd0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      we_q      <= 4'b0000;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      sel_q     <= sel_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign busy       = (state_q != WB_IDLE);
  assign frame_done = (state_q == WB_DONE);

endmodule : row_write_back

`default_nettype wire

// File: tb/tb_row_write_back.sv
// ============================================================================
// tb_row_write_back
// Self-checking bench for row_write_back: control table, latency, stall,
// abort, reset and full-frame sequences against a scoreboard of expected
// SRAM writes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_row_write_back;
  import sift_pkg::*;

  localparam int ROW_W    = 5120;
  localparam int ADDR_W   = 9;
  localparam int NUM_ROWS = 480;
`ifdef ROW_WB_BORDER_ZERO_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [2:0]        sys_mode;
  logic              start;
  logic [1:0]        blur_sel;
  logic              in_valid;
  logic              in_ready;
  logic [ROW_W-1:0]  in_data;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [ROW_W-1:0]  sram_wdata;
  logic              busy;
  logic              frame_done;

  row_write_back #(
    .ROW_W    (ROW_W),
    .ADDR_W   (ADDR_W),
    .NUM_ROWS (NUM_ROWS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sys_mode   (sys_mode),
    .start      (start),
    .blur_sel   (blur_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [ROW_W-1:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  n_total = 0;
  int  n_pass  = 0;
  int  n_writes = 0;
  int  n_fd = 0;
  int  n_extra = 0;
  int  m_acc = 0;
  int  m_wr = 0;
  bit  m_active = 1'b0;
  logic [1:0] m_sel = 2'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    int first;
    n_total++;
    if (act === exp) n_pass++;
    else begin
      first = -1;
      for (int i = 0; i < ROW_W; i++) if (first < 0 && act[i] !== exp[i]) first = i;
      $display("FAIL %s: got low64 %h expected low64 %h (first bad bit %0d)",
               name, act[63:0], exp[63:0], first);
    end
  endtask

  // Rows at the frame border are written as zero when that build option is on
  function automatic logic [ROW_W-1:0] exp_row(input int idx, input logic [ROW_W-1:0] d);
    if (BORDER_EN && (idx < 2 || idx >= NUM_ROWS - 2)) return '0;
    return d;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < ROW_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Check every SRAM write against the next expected row
  always @(negedge clk) begin
    if (rst_n) begin
      if (sram_we != 4'b0000) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write_we", {60'd0, sram_we}, 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_we", {60'd0, sram_we}, {60'd0, e.we});
          chk("wr_addr", {55'd0, sram_addr}, {55'd0, e.addr});
          chk_row("wr_data", sram_wdata, e.data);
          m_wr++;
          if (m_wr == NUM_ROWS) m_active = 1'b0;
        end
      end
      if (frame_done) n_fd++;
    end
  end

  // One clock: sample the handshake before the edge, update the model after it
  task automatic cycle();
    logic acc, abort_now, start_now;
    logic [ROW_W-1:0] d;
    acc       = rst_n && in_valid && in_ready && (sys_mode != SYS_IDLE);
    abort_now = !rst_n || (sys_mode == SYS_IDLE);
    start_now = start && (sys_mode == SYS_GAUSSIAN) && !m_active;
    d         = in_data;
    @(posedge clk);
    if (abort_now) begin
      exp_q.delete();
      m_acc = 0;
      m_active = 1'b0;
    end else begin
      if (start_now) begin
        m_active = 1'b1;
        m_sel = blur_sel;
        m_acc = 0;
        m_wr = 0;
      end
      if (acc) begin
        wr_t e;
        if (m_acc >= NUM_ROWS) n_extra++;
        e.we   = 4'b0001 << m_sel;
        e.addr = ADDR_W'(m_acc);
        e.data = exp_row(m_acc, d);
        exp_q.push_back(e);
        m_acc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic start_frame(input logic [1:0] sel);
    sys_mode = SYS_GAUSSIAN;
    start    = 1'b1;
    blur_sel = sel;
    cycle();
    start    = 1'b0;
  endtask

  task automatic abort_frame();
    sys_mode = SYS_IDLE;
    in_valid = 1'b0;
    cycle();
    sys_mode = SYS_GAUSSIAN;
  endtask

  // Full frame of back-to-back rows; a start pulse mid-frame must be ignored
  task automatic run_frame(input logic [1:0] sel, input bit ones, input string tag);
    int cyc, fd0, w0;
    logic [ROW_W-1:0] all1;
    all1 = '1;
    fd0  = n_fd;
    start_frame(sel);
    w0   = n_writes;
    cyc  = 0;
    in_valid = 1'b1;
    while (m_acc < NUM_ROWS && cyc < 2000) begin
      in_data  = ones ? all1 : rand_row();
      start    = (m_acc == 200);
      blur_sel = 2'd1;
      cycle();
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_accept_cycles"}, 64'(cyc), 64'(NUM_ROWS));
    chk({tag, "_ready_low_after_last"}, {63'd0, in_ready}, 64'd0);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 50 && m_wr < NUM_ROWS; i++) cycle();
    for (int i = 0; i < 4; i++) cycle();
    chk({tag, "_write_count"}, 64'(n_writes - w0), 64'(NUM_ROWS));
    chk({tag, "_frame_done_pulses"}, 64'(n_fd - fd0), 64'd1);
    chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Control table: one clock per entry, outputs checked after the edge
  typedef struct {
    logic [2:0] mode;
    logic       st;
    logic [1:0] sel;
    logic       rdy;
    logic       bsy;
    logic [3:0] we;
    logic       fd;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROW_W-1:0] pat, r0, r1, r2, e0;
    int w0, fd0;
    pat = {(ROW_W/8){8'hA5}};

    tbl[0] = '{SYS_DETECT_FILTER, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[1] = '{SYS_GAUSSIAN,      1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[2] = '{SYS_GAUSSIAN,      1'b1, 2'd2, 1'b1, 1'b1, 4'b0000, 1'b0};
    tbl[3] = '{SYS_GAUSSIAN,      1'b1, 2'd1, 1'b1, 1'b1, 4'b0000, 1'b0};
    tbl[4] = '{SYS_DETECT_FILTER, 1'b0, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b0};
    tbl[5] = '{SYS_IDLE,          1'b1, 2'd3, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[6] = '{SYS_IDLE,          1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[7] = '{SYS_GAUSSIAN,      1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0};

    rst_n = 1'b0; sys_mode = SYS_IDLE; start = 1'b0; blur_sel = 2'd0;
    in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    cycle();
    cycle();
    // Reset state
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_we", {60'd0, sram_we}, 64'd0);
    chk("rst_addr", {55'd0, sram_addr}, 64'd0);
    chk_row("rst_wdata", sram_wdata, '0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
    rst_n = 1'b1;
    cycle();

    // Start acceptance / ignore table
    for (int i = 0; i < 8; i++) begin
      sys_mode = tbl[i].mode;
      start    = tbl[i].st;
      blur_sel = tbl[i].sel;
      cycle();
      chk($sformatf("tbl%0d_in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].rdy});
      chk($sformatf("tbl%0d_busy", i), {63'd0, busy}, {63'd0, tbl[i].bsy});
      chk($sformatf("tbl%0d_we", i), {60'd0, sram_we}, {60'd0, tbl[i].we});
      chk($sformatf("tbl%0d_frame_done", i), {63'd0, frame_done}, {63'd0, tbl[i].fd});
    end
    start = 1'b0;

    // Latency into an empty FIFO
    start_frame(2'd0);
    in_valid = 1'b1;
    in_data  = pat;
    cycle();                       // handshake edge k
    in_valid = 1'b0;
    chk("lat_we_after_k", {60'd0, sram_we}, 64'd0);
    cycle();                       // pop edge k+1
    e0 = exp_row(0, pat);
    chk("lat_we_after_k1", {60'd0, sram_we}, 64'd1);
    chk("lat_addr", {55'd0, sram_addr}, 64'd0);
    chk_row("lat_wdata", sram_wdata, e0);
    cycle();
    chk("lat_we_single", {60'd0, sram_we}, 64'd0);
    abort_frame();

    // Writer stalled by a non-Gaussian mode: FIFO fills, in_ready drops
    w0 = n_writes;
    r0 = rand_row(); r1 = rand_row(); r2 = rand_row();
    start_frame(2'd1);
    sys_mode = SYS_DETECT_FILTER;
    in_valid = 1'b1;
    in_data  = r0;
    chk("stall_rdy0", {63'd0, in_ready}, 64'd1);
    cycle();
    in_data = r1;
    chk("stall_rdy1", {63'd0, in_ready}, 64'd1);
    cycle();
    in_data = r2;
    chk("stall_full_a", {63'd0, in_ready}, 64'd0);
    cycle();
    chk("stall_full_b", {63'd0, in_ready}, 64'd0);
    chk("stall_no_write", {60'd0, sram_we}, 64'd0);
    cycle();
    sys_mode = SYS_GAUSSIAN;
    chk("stall_full_c", {63'd0, in_ready}, 64'd0);
    cycle();
    chk("stall_resume_rdy", {63'd0, in_ready}, 64'd1);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("stall_writes", 64'(n_writes - w0), 64'd3);
    chk("stall_pending", 64'(exp_q.size()), 64'd0);
    chk("stall_busy", {63'd0, busy}, 64'd1);
    abort_frame();

    // Abort after 100 rows, then restart at address 0
    fd0 = n_fd;
    start_frame(2'd3);
    in_valid = 1'b1;
    for (int i = 0; i < 200 && m_acc < 100; i++) begin
      in_data = rand_row();
      cycle();
    end
    in_valid = 1'b0;
    sys_mode = SYS_IDLE;
    cycle();
    chk("abort_we", {60'd0, sram_we}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
    cycle();
    chk("abort_we_hold", {60'd0, sram_we}, 64'd0);
    chk("abort_no_frame_done", 64'(n_fd - fd0), 64'd0);
    start_frame(2'd3);
    in_valid = 1'b1;
    in_data  = rand_row();
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("restart_addr", {55'd0, sram_addr}, 64'd0);
    chk("restart_we", {60'd0, sram_we}, 64'd8);
    abort_frame();

    // Reset in the middle of a frame
    start_frame(2'd2);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = rand_row();
      cycle();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    chk("midrst_we", {60'd0, sram_we}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("midrst_addr", {55'd0, sram_addr}, 64'd0);
    w0 = n_writes;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("midrst_no_writes", 64'(n_writes - w0), 64'd0);

    // Full frames: random data on SRAM 2, then all-ones rows on SRAM 0
    run_frame(2'd2, 1'b0, "frame_rand");
    run_frame(2'd0, 1'b1, "frame_ones");

    chk("extra_rows_accepted", 64'(n_extra), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_row_write_back

`default_nettype wire
